// File: rtl/generic_array_pkg.sv
// Shared definitions for the combined array multiplier / divider.
// Mode encoding on MUL_BAR plus default geometry and result-width helpers.
package generic_array_pkg;

  typedef enum logic {
    MUL = 1'b0,
    DIV = 1'b1
  } mode_e;

  localparam int DEF_NO_ROWS     = 10;
  localparam int DEF_NO_BITS_DIV = 5;

  function automatic int out_w(input int rows, input int bits);
    return rows + bits - 1;
  endfunction

  localparam int OUT_W = out_w(DEF_NO_ROWS, DEF_NO_BITS_DIV);

endpackage

// File: rtl/generic_array_cell.sv
// Controlled add/subtract cell: full adder with the B input inverted on sub,
// and an output mux that either keeps the sum or passes/restores the A input.
module array_cell (
  input  logic a,
  input  logic b,
  input  logic sub,
  input  logic cin,
  input  logic sel,
  output logic sum_out,
  output logic cout
);

  logic bx;
  logic s;

  assign bx      = b ^ sub;
  assign s       = a ^ bx ^ cin;
  assign cout    = (a & bx) | (a & cin) | (bx & cin);
  assign sum_out = sel ? s : a;

endmodule

// File: rtl/generic_array.sv
// Unsigned array multiplier / restoring divider sharing one cell array,
// with a single registered output stage.
module generic_array
  import generic_array_pkg::*;
#(
  parameter int NO_ROWS     = DEF_NO_ROWS,
  parameter int NO_BITS_DIV = DEF_NO_BITS_DIV
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic [NO_ROWS-1:0]             Y,
  input  logic [NO_BITS_DIV-1:0]         X,
  input  logic                           MUL_BAR,
  output logic [NO_ROWS+NO_BITS_DIV-2:0] REM_MUL_OUT,
  output logic [NO_ROWS-1:0]             Q
);

  localparam int NB    = NO_BITS_DIV;
  localparam int RES_W = out_w(NO_ROWS, NO_BITS_DIV);

  mode_e            mode;
  logic             is_div;
  logic             div_zero;
  logic [NB-1:0]    b_op;
  logic [NO_ROWS-1:0] q_bits;
  logic [NO_ROWS-1:0] p_low;
  logic [RES_W-1:0] res_mul;
  logic [RES_W-1:0] res_div;
  logic [RES_W-1:0] res_nxt;
  logic [NO_ROWS-1:0] q_nxt;

  assign mode     = mode_e'(MUL_BAR);
  assign is_div   = (mode == DIV);
  assign div_zero = (X[NB-2:0] == '0);
  // The divisor drops the top X bit; the multiplier uses all of X.
  assign b_op     = is_div ? {1'b0, X[NB-2:0]} : X;

  // Row i: MUL adds X into the running partial sum when Y[i] is set;
  // DIV shifts in the next dividend bit (MSB first) and trial-subtracts D.
  for (genvar i = 0; i < NO_ROWS; i++) begin : row
    logic [NB-1:0] a;
    logic [NB-1:0] r;
    logic          sel;

    if (i == 0) begin : g_a
      assign a = is_div ? {{(NB-1){1'b0}}, Y[NO_ROWS-1]} : '0;
    end else begin : g_a
      assign a = is_div ? {row[i-1].r[NB-2:0], Y[NO_ROWS-1-i]}
                        : {row[i-1].g_cy.cy, row[i-1].r[NB-1:1]};
    end

    for (genvar j = 0; j < NB; j++) begin : col
      logic ci;
      logic co;
      if (j == 0) begin : g_ci
        assign ci = is_div;
      end else begin : g_ci
        assign ci = col[j-1].co;
      end
      array_cell u_cell (
        .a       (a[j]),
        .b       (b_op[j]),
        .sub     (is_div),
        .cin     (ci),
        .sel     (sel),
        .sum_out (r[j]),
        .cout    (co)
      );
    end

    // In DIV a carry out of the row means no borrow: keep the difference.
    assign sel = is_div ? col[NB-1].co : Y[i];

    if (i < NO_ROWS - 1) begin : g_cy
      logic cy;
      assign cy = ~is_div & Y[i] & col[NB-1].co;
    end

    assign q_bits[NO_ROWS-1-i] = sel;
    assign p_low[i]            = r[0];
  end

  assign res_mul = {row[NO_ROWS-1].r[NB-1:1], p_low};
  assign res_div = div_zero ? {{(NB-1){1'b0}}, Y}
                            : {{NO_ROWS{1'b0}}, row[NO_ROWS-1].r[NB-2:0]};
  assign res_nxt = is_div ? res_div : res_mul;
  assign q_nxt   = is_div ? (div_zero ? '1 : q_bits) : '0;

  // Output register stage
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      REM_MUL_OUT <= '0;
      Q           <= '0;
    end else begin
      REM_MUL_OUT <= res_nxt;
      Q           <= q_nxt;
    end
  end

endmodule

// File: tb/tb_generic_array.sv
// Self-checking bench for generic_array: directed cases, alternating modes,
// reset behaviour and a random sweep against an arithmetic reference model.
module tb_generic_array;
  import generic_array_pkg::*;

  logic             CLK;
  logic             RST_N;
  logic [9:0]       Y;
  logic [4:0]       X;
  logic             MUL_BAR;
  logic [OUT_W-1:0] REM_MUL_OUT;
  logic [9:0]       Q;

  int n_checks = 0;
  int n_errors = 0;

  generic_array #(.NO_ROWS(10), .NO_BITS_DIV(5)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .Y           (Y),
    .X           (X),
    .MUL_BAR     (MUL_BAR),
    .REM_MUL_OUT (REM_MUL_OUT),
    .Q           (Q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic void model(input int y, input int x, input bit div,
                                output int rem, output int quo);
    int d;
    d = x % 16;
    if (!div) begin
      rem = (y * x) % (1 << OUT_W);
      quo = 0;
    end else if (d == 0) begin
      rem = y;
      quo = 1023;
    end else begin
      rem = y % d;
      quo = y / d;
    end
  endfunction

  // Present an operation at the falling edge, check it one rising edge later.
  task automatic run_op(input string tag, input int y, input int x, input bit div);
    int er, eq;
    Y       = 10'(y);
    X       = 5'(x);
    MUL_BAR = div;
    model(y, x, div, er, eq);
    @(posedge CLK);
    @(negedge CLK);
    check({tag, "_rem"}, 32'(REM_MUL_OUT), 32'(er));
    check({tag, "_q"},   32'(Q),           32'(eq));
  endtask

  int dy [21] = '{2, 15, 21, 31, 31, 0,
                  5, 119, 365, 341, 1023, 1023, 3, 1, 3, 100, 777, 0, 1023, 512, 1023};
  int dx [21] = '{2, 3, 15, 31, 0, 0,
                  2, 13, 15, 8, 15, 1, 15, 1, 0, 19, 16, 7, 31, 31, 7};
  bit dd [21] = '{0, 0, 0, 0, 0, 0,
                  1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1};

  initial begin
    int er, eq;
    RST_N   = 1'b0;
    Y       = 10'($urandom);
    X       = 5'($urandom);
    MUL_BAR = 1'($urandom);
    #12;
    check("reset_rem", 32'(REM_MUL_OUT), 32'd0);
    check("reset_q",   32'(Q),           32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    for (int i = 0; i < 21; i++)
      run_op($sformatf("dir%0d", i), dy[i], dx[i], dd[i]);

    for (int i = 0; i < 24; i++)
      run_op($sformatf("alt%0d", i), int'($urandom_range(0, 1023)),
             int'($urandom_range(0, 31)), bit'(i % 2));

    // Reset mid-operation clears outputs without a clock edge.
    Y = 10'd1000; X = 5'd9; MUL_BAR = 1'b1;
    #2 RST_N = 1'b0;
    #1;
    check("midrst_rem", 32'(REM_MUL_OUT), 32'd0);
    check("midrst_q",   32'(Q),           32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    model(1000, 9, 1'b1, er, eq);
    @(posedge CLK);
    @(negedge CLK);
    check("release_rem", 32'(REM_MUL_OUT), 32'(er));
    check("release_q",   32'(Q),           32'(eq));

    for (int i = 0; i < 300; i++)
      run_op($sformatf("rnd%0d", i), int'($urandom_range(0, 1023)),
             int'($urandom_range(0, 31)), bit'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
